// File: rtl/serv_rf_dbg_client.sv
// serv_rf_dbg_client: debug-host initiator on SERV register-file port 0.
// Turns one parallel read/write command into an rreq/wreq handshake plus a
// 32-cycle LSB-first serial transfer, then returns a one-cycle response.
module serv_rf_dbg_client #(
    parameter int csr_regs = 4,
    parameter int timeout  = 15,
    localparam int RW = $clog2(32 + csr_regs)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // host command
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_we,
    input  logic [RW-1:0] i_cmd_reg,
    input  logic [31:0]   i_cmd_wdata,
    // host response
    output logic          o_rsp_valid,
    output logic          o_rsp_err,
    output logic [31:0]   o_rsp_rdata,
    // register-file RAM interface
    output logic          o_rreq,
    output logic          o_wreq,
    input  logic          i_ready,
    output logic [RW-1:0] o_rreg0,
    output logic [RW-1:0] o_rreg1,
    output logic [RW-1:0] o_wreg0,
    output logic [RW-1:0] o_wreg1,
    output logic          o_wen0,
    output logic          o_wen1,
    output logic          o_wdata0,
    output logic          o_wdata1,
    input  logic          i_rdata0,
    input  logic          i_rdata1
);

    typedef enum logic [2:0] {
        IDLE,
        RREQ,
        RWAIT,
        RSHIFT,
        WREQ,
        WSHIFT,
        RESP
    } state_t;

    localparam int unsigned NREGS   = 32 + csr_regs;
    localparam logic [7:0]  TO_LAST = 8'(timeout - 1);

    state_t        state;
    state_t        state_nxt;

    logic [RW-1:0] reg_q;
    logic          we_q;
    logic          err_q;
    logic [31:0]   shreg;
    logic [4:0]    bcnt;
    logic [7:0]    tcnt;
    logic          wfirst;

    logic          cmd_fire;
    logic          cmd_illegal;
    logic          rwait_expire;
    logic          unused_rdata1;

    assign unused_rdata1 = i_rdata1;
    assign cmd_fire      = (state == IDLE) && i_cmd_valid;
    assign cmd_illegal   = 32'(i_cmd_reg) >= NREGS;
    assign rwait_expire  = !i_ready && (tcnt >= TO_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, shift register, bit counter and timeout counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reg_q  <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            shreg  <= '0;
            bcnt   <= '0;
            tcnt   <= '0;
            wfirst <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        reg_q  <= i_cmd_reg;
                        we_q   <= i_cmd_we;
                        err_q  <= cmd_illegal;
                        shreg  <= i_cmd_wdata;
                        bcnt   <= '0;
                        tcnt   <= '0;
                        wfirst <= 1'b1;
                    end
                end
                RWAIT: begin
                    if (!i_ready) begin
                        if (tcnt != 8'hFF) begin
                            tcnt <= tcnt + 8'd1;
                        end
                        if (rwait_expire) begin
                            err_q <= 1'b1;
                            shreg <= '0;
                        end
                    end
                end
                RSHIFT: begin
                    shreg <= {i_rdata0, shreg[31:1]};
                    bcnt  <= bcnt + 5'd1;
                end
                WSHIFT: begin
                    // First WSHIFT cycle raises wen with no data; bits follow.
                    if (wfirst) begin
                        wfirst <= 1'b0;
                    end else begin
                        shreg <= {1'b0, shreg[31:1]};
                        bcnt  <= bcnt + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and all interface outputs
    always_comb begin
        state_nxt   = state;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = '0;
        o_rreq      = 1'b0;
        o_wreq      = 1'b0;
        o_rreg0     = '0;
        o_rreg1     = '0;
        o_wreg0     = '0;
        o_wreg1     = '0;
        o_wen0      = 1'b0;
        o_wen1      = 1'b0;
        o_wdata0    = 1'b0;
        o_wdata1    = 1'b0;

        if (state != IDLE) begin
            o_rreg0 = reg_q;
            o_rreg1 = reg_q;
            o_wreg0 = reg_q;
        end

        case (state)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                o_cmd_ready = i_rst_n;
                if (cmd_fire) begin
                    if (cmd_illegal) begin
                        state_nxt = RESP;
                    end else if (i_cmd_we) begin
                        state_nxt = WREQ;
                    end else begin
                        state_nxt = RREQ;
                    end
                end
            end
            RREQ: begin
                o_rreq    = 1'b1;
                state_nxt = RWAIT;
            end
            RWAIT: begin
                if (i_ready) begin
                    state_nxt = RSHIFT;
                end else if (rwait_expire) begin
                    state_nxt = RESP;
                end
            end
            RSHIFT: begin
                if (bcnt == 5'd31) begin
                    state_nxt = RESP;
                end
            end
            WREQ: begin
                o_wreq = 1'b1;
                if (i_ready) begin
                    state_nxt = WSHIFT;
                end
            end
            WSHIFT: begin
                o_wen0   = (reg_q != '0);
                o_wdata0 = !wfirst && shreg[0];
                if (!wfirst && (bcnt == 5'd31)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = err_q;
                if (!we_q && !err_q) begin
                    o_rsp_rdata = shreg;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serv_rf_dbg_client.sv
// tb_serv_rf_dbg_client: directed bench for serv_rf_dbg_client with a small
// register-file responder model (rf[]) that serves reads and captures writes.
module tb_serv_rf_dbg_client;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [5:0]  i_cmd_reg;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic        o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic        o_rreq;
    logic        o_wreq;
    logic        i_ready;
    logic [5:0]  o_rreg0;
    logic [5:0]  o_rreg1;
    logic [5:0]  o_wreg0;
    logic [5:0]  o_wreg1;
    logic        o_wen0;
    logic        o_wen1;
    logic        o_wdata0;
    logic        o_wdata1;
    logic        i_rdata0;
    logic        i_rdata1;

    logic        ready_drv;
    logic        wr_comb;

    int tests_run;
    int tests_failed;

    logic [31:0] rf [0:63];

    // per-transaction observations
    int          rsp_off;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic        ready_at0;
    int          rreq_cnt;
    int          rreq_first;
    int          wreq_cnt;
    int          both_cnt;
    int          wen_cnt;
    int          wen_first;
    int          wen_last;
    int          wdata_stray;
    logic [31:0] wcap;
    logic [5:0]  rreg0_1;
    logic [5:0]  rreg1_1;
    logic [5:0]  wreg0_1;
    logic        aborted;

    assign i_ready  = ready_drv | (wr_comb & o_wreq);
    assign i_rdata1 = 1'b0;

    serv_rf_dbg_client #(
        .csr_regs (4),
        .timeout  (15)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_we    (i_cmd_we),
        .i_cmd_reg   (i_cmd_reg),
        .i_cmd_wdata (i_cmd_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_err   (o_rsp_err),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rreq      (o_rreq),
        .o_wreq      (o_wreq),
        .i_ready     (i_ready),
        .o_rreg0     (o_rreg0),
        .o_rreg1     (o_rreg1),
        .o_wreg0     (o_wreg0),
        .o_wreg1     (o_wreg1),
        .o_wen0      (o_wen0),
        .o_wen1      (o_wen1),
        .o_wdata0    (o_wdata0),
        .o_wdata1    (o_wdata1),
        .i_rdata0    (i_rdata0),
        .i_rdata1    (i_rdata1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one command at the current cycle C (offset 0) and observe it
    // cycle by cycle. grant: offset at which ready_drv pulses (-1 = never).
    // abort_at: offset at which to stop observing without finishing (-1 = none).
    task automatic run_cmd(input logic we, input logic [5:0] r, input logic [31:0] wd,
                           input int grant, input int abort_at);
        int w_exp;
        w_exp       = (we && wr_comb) ? 1 : grant;
        rsp_off     = -1;
        rsp_err     = 1'b0;
        rsp_data    = '0;
        rsp_ready   = 1'b0;
        ready_at0   = 1'b0;
        rreq_cnt    = 0;
        rreq_first  = -1;
        wreq_cnt    = 0;
        both_cnt    = 0;
        wen_cnt     = 0;
        wen_first   = -1;
        wen_last    = -1;
        wdata_stray = 0;
        wcap        = '0;
        aborted     = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_reg   = r;
        i_cmd_wdata = wd;
        for (int off = 0; off < 80; off++) begin
            if (off == 1) i_cmd_valid = 1'b0;
            ready_drv = (grant >= 0) && (off == grant);
            if (!we && grant >= 0 && off > grant && off <= grant + 32)
                i_rdata0 = rf[r][off - grant - 1];
            else
                i_rdata0 = 1'b0;
            if (off == 0) ready_at0 = o_cmd_ready;
            if (off == 1) begin
                rreg0_1 = o_rreg0;
                rreg1_1 = o_rreg1;
                wreg0_1 = o_wreg0;
            end
            if (o_rreq) begin
                rreq_cnt++;
                if (rreq_first < 0) rreq_first = off;
            end
            if (o_wreq) wreq_cnt++;
            if (o_rreq && o_wreq) both_cnt++;
            if (o_wen0) begin
                wen_cnt++;
                if (wen_first < 0) wen_first = off;
                wen_last = off;
            end
            if (we && w_exp >= 0 && off >= w_exp + 2 && off <= w_exp + 33)
                wcap[off - w_exp - 2] = o_wdata0;
            else if (o_wdata0)
                wdata_stray++;
            if (o_rsp_valid) begin
                rsp_off   = off;
                rsp_err   = o_rsp_err;
                rsp_data  = o_rsp_rdata;
                rsp_ready = o_cmd_ready;
                break;
            end
            if (off == abort_at) begin
                aborted = 1'b1;
                break;
            end
            tick();
        end
        ready_drv = 1'b0;
        i_rdata0  = 1'b0;
        if (!aborted) begin
            if (rsp_off < 0) check("rsp_seen", 32'd0, 32'd1);
            else tick();
            if (we && wen_cnt > 0 && rsp_off >= 0) rf[r] = wcap;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int unsigned i = 0; i < 64; i++) rf[i] = '0;
        rf[5] = 32'hDEAD_BEEF;

        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_we    = 1'b0;
        i_cmd_reg   = '0;
        i_cmd_wdata = '0;
        i_rdata0    = 1'b0;
        ready_drv   = 1'b0;
        wr_comb     = 1'b0;

        // reset state
        #2;
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);
        check("idle_rreg0", 32'(o_rreg0), 32'd0);
        check("idle_rreq", 32'(o_rreq), 32'd0);

        // read x5, grant at C+3
        run_cmd(1'b0, 6'd5, 32'h0, 3, -1);
        check("rd5_accept", 32'(ready_at0), 32'd1);
        check("rd5_rsp_cyc", 32'(rsp_off), 32'd36);
        check("rd5_data", rsp_data, 32'hDEAD_BEEF);
        check("rd5_err", 32'(rsp_err), 32'd0);
        check("rd5_rreq_cnt", 32'(rreq_cnt), 32'd1);
        check("rd5_rreq_cyc", 32'(rreq_first), 32'd1);
        check("rd5_wreq_cnt", 32'(wreq_cnt), 32'd0);
        check("rd5_rreg0", 32'(rreg0_1), 32'd5);
        check("rd5_rreg1", 32'(rreg1_1), 32'd5);
        check("rd5_wreg0", 32'(wreg0_1), 32'd5);
        check("rd5_rsp_notready", 32'(rsp_ready), 32'd0);

        // write x7, ready combinational on wreq
        wr_comb = 1'b1;
        run_cmd(1'b1, 6'd7, 32'hA5A5_0F0F, -1, -1);
        check("wr7_rsp_cyc", 32'(rsp_off), 32'd35);
        check("wr7_err", 32'(rsp_err), 32'd0);
        check("wr7_rdata", rsp_data, 32'h0);
        check("wr7_wen_first", 32'(wen_first), 32'd2);
        check("wr7_wen_last", 32'(wen_last), 32'd34);
        check("wr7_wen_cnt", 32'(wen_cnt), 32'd33);
        check("wr7_wdata", wcap, 32'hA5A5_0F0F);
        check("wr7_wdata_stray", 32'(wdata_stray), 32'd0);
        check("wr7_wreq_cnt", 32'(wreq_cnt), 32'd1);
        check("wr7_rreq_cnt", 32'(rreq_cnt), 32'd0);
        wr_comb = 1'b0;
        run_cmd(1'b0, 6'd7, 32'h0, 3, -1);
        check("rb7_data", rsp_data, 32'hA5A5_0F0F);

        // write x0: handshake runs, no write enable
        wr_comb = 1'b1;
        run_cmd(1'b1, 6'd0, 32'hFFFF_FFFF, -1, -1);
        check("wr0_wreq_cnt", 32'(wreq_cnt), 32'd1);
        check("wr0_wen_cnt", 32'(wen_cnt), 32'd0);
        check("wr0_err", 32'(rsp_err), 32'd0);
        check("wr0_rsp_cyc", 32'(rsp_off), 32'd35);
        wr_comb = 1'b0;
        run_cmd(1'b0, 6'd0, 32'h0, 3, -1);
        check("rb0_data", rsp_data, 32'h0);

        // write x9 with grant delayed to C+4: wreq held until ready
        run_cmd(1'b1, 6'd9, 32'h1357_9BDF, 4, -1);
        check("wr9_wreq_cnt", 32'(wreq_cnt), 32'd4);
        check("wr9_wen_first", 32'(wen_first), 32'd5);
        check("wr9_rsp_cyc", 32'(rsp_off), 32'd38);
        check("wr9_wdata", wcap, 32'h1357_9BDF);
        check("wr9_both", 32'(both_cnt), 32'd0);

        // read timeout, then back-to-back command at C+18
        run_cmd(1'b0, 6'd9, 32'h0, -1, -1);
        check("to_rsp_cyc", 32'(rsp_off), 32'd17);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_data", rsp_data, 32'h0);
        run_cmd(1'b0, 6'd9, 32'h0, 3, -1);
        check("to_next_accept", 32'(ready_at0), 32'd1);
        check("rb9_data", rsp_data, 32'h1357_9BDF);

        // illegal indices
        run_cmd(1'b0, 6'd36, 32'h0, 3, -1);
        check("ill_rsp_cyc", 32'(rsp_off), 32'd1);
        check("ill_err", 32'(rsp_err), 32'd1);
        check("ill_rreq_cnt", 32'(rreq_cnt), 32'd0);
        check("ill_wreq_cnt", 32'(wreq_cnt), 32'd0);
        wr_comb = 1'b1;
        run_cmd(1'b1, 6'd37, 32'h1234_5678, -1, -1);
        check("illw_rsp_cyc", 32'(rsp_off), 32'd1);
        check("illw_err", 32'(rsp_err), 32'd1);
        check("illw_wreq_cnt", 32'(wreq_cnt), 32'd0);
        check("illw_wen_cnt", 32'(wen_cnt), 32'd0);

        // reset during write bit 10 (cycle C+13)
        run_cmd(1'b1, 6'd7, 32'h0F0F_F0F0, -1, 13);
        check("rst_mid_wen_before", 32'(o_wen0), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_wen0", 32'(o_wen0), 32'd0);
        check("rst_mid_wreq", 32'(o_wreq), 32'd0);
        check("rst_mid_wdata0", 32'(o_wdata0), 32'd0);
        check("rst_mid_wreg0", 32'(o_wreg0), 32'd0);
        check("rst_mid_rsp", 32'(o_rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(o_cmd_ready), 32'd0);
        wr_comb = 1'b0;
        begin
            int rsp_seen;
            rsp_seen = 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (o_rsp_valid) rsp_seen++;
            end
            i_rst_n = 1'b1;
            for (int i = 0; i < 2; i++) begin
                tick();
                if (o_rsp_valid) rsp_seen++;
            end
            check("rst_no_rsp", 32'(rsp_seen), 32'd0);
        end
        run_cmd(1'b0, 6'd7, 32'h0, 3, -1);
        check("post_rst_rsp_cyc", 32'(rsp_off), 32'd36);
        check("post_rst_data", rsp_data, 32'hA5A5_0F0F);
        check("post_rst_err", 32'(rsp_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
